// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings, counter widths and the bundled control-output type.
package pipe_hazard_ctrl_pkg;

  // Pipeline-control FSM encodings (also exported on state_o for debug)
  typedef enum logic [1:0] {
    PHC_RUN      = 2'd0,
    PHC_LU_STALL = 2'd1,
    PHC_MEM_WAIT = 2'd2
  } phc_state_t;

  // Wait counter must hold MEM_TIMEOUT values up to 255
  localparam int WAIT_W = 8;

  // Hold-enable / flush controls driven into the passive pipeline registers
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_flush;
  } phc_ctl_t;

  localparam phc_ctl_t CTL_IDLE   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                      idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
                                      exmem_flush: 1'b0, memwb_flush: 1'b0};
  localparam phc_ctl_t CTL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                      idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0,
                                      exmem_flush: 1'b1, memwb_flush: 1'b1};
  localparam phc_ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0,
                                      exmem_flush: 1'b0, memwb_flush: 1'b1};
  localparam phc_ctl_t CTL_FLUSH  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1,
                                      exmem_flush: 1'b1, memwb_flush: 1'b0};
  localparam phc_ctl_t CTL_STALL  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1,
                                      exmem_flush: 1'b0, memwb_flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// phc_hazard_detect: purely combinational load-use hazard detector.
// Flags an ID instruction that reads the register being loaded by ID/EX.
module phc_hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       lu_hit
);

  logic rs_hit;
  logic rt_hit;

  // $zero is never a real dependency, so a load into r0 is ignored
  assign rs_hit = id_use_rs & (id_rs == ex_rd);
  assign rt_hit = id_use_rt & (id_rt == ex_rd);
  assign lu_hit = ex_memread & (ex_rd != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Priority in every state: memory wait > branch redirect > load-use stall.
// Optional macro PIPE_PERF_CNT_EN adds saturating performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int MEM_TIMEOUT    = 255
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W        = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       br_taken,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       mem_err,
  output logic [1:0] state_o
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] lu_stall_cnt
  , output logic [CNT_W-1:0] mem_wait_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  phc_state_t        state, state_n;
  logic [1:0]        lu_cnt, lu_cnt_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  phc_ctl_t          ctl;
  logic              lu_hit;
  logic              mw;
  logic              timeout;
  logic              freeze;
  logic              redirect;
  logic              lu_stall;

  phc_hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .lu_hit     (lu_hit)
  );

  // Prioritised hazard decode shared by the next-state and output logic.
  // A timed-out access is treated like an ack, so branch/load-use rules
  // still apply in the abort cycle.
  assign mw       = mem_req & ~mem_ack;
  assign timeout  = mw & (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign freeze   = mw & ~timeout;
  assign redirect = ~freeze & br_taken;
  assign lu_stall = ~freeze & ~br_taken & ((state == PHC_LU_STALL) | lu_hit);

  // State register, stall/wait counters and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PHC_RUN;
      lu_cnt   <= 2'd0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state    <= state_n;
      lu_cnt   <= lu_cnt_n;
      wait_cnt <= wait_cnt_n;
      mem_err  <= mem_err | timeout;
    end
  end

  // Next-state and counter update
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_n    = PHC_RUN;
    lu_cnt_n   = lu_cnt;
    wait_cnt_n = '0;
    if (freeze) begin
      // Memory not ready: hold everything, lu_cnt frozen
      state_n    = PHC_MEM_WAIT;
      wait_cnt_n = wait_cnt + 1'b1;
    end else if (timeout) begin
      lu_cnt_n = 2'd0;
    end else if (br_taken) begin
      // Redirect kills any load-use stall in progress
      lu_cnt_n = 2'd0;
    end else if (state == PHC_LU_STALL) begin
      if (lu_cnt > 2'd1) begin
        lu_cnt_n = lu_cnt - 2'd1;
        state_n  = PHC_LU_STALL;
      end else begin
        lu_cnt_n = 2'd0;
      end
    end else if (lu_hit) begin
      if (LOAD_USE_STALL > 1) begin
        lu_cnt_n = 2'(LOAD_USE_STALL - 1);
        state_n  = PHC_LU_STALL;
      end
    end else if (lu_cnt != 2'd0) begin
      // Memory wait interrupted a load-use stall: resume it
      state_n = PHC_LU_STALL;
    end
  end

  // Control outputs; reset forces every stage to bubble
  always_comb begin
    ctl = CTL_IDLE;
    if (rst) begin
      ctl = CTL_RESET;
    end else if (freeze) begin
      ctl = CTL_FREEZE;
    end else begin
      if (redirect) begin
        ctl = CTL_FLUSH;
      end else if (lu_stall) begin
        ctl = CTL_STALL;
      end
      if (timeout) begin
        // Abort: drop the stuck access and keep it from writing back
        ctl.exmem_flush = 1'b1;
        ctl.memwb_flush = 1'b1;
      end
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_en     = ctl.idex_en;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_en    = ctl.exmem_en;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_flush = ctl.memwb_flush;
  assign state_o     = state;

`ifdef PIPE_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_stall_cnt <= '0;
      mem_wait_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (lu_stall && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if ((state == PHC_MEM_WAIT) && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + 1'b1;
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Two instances share stimulus:
// A uses LOAD_USE_STALL=1, B uses LOAD_USE_STALL=2; both MEM_TIMEOUT=4.
// Expected vector per cycle: {pc_en, ifid_en, ifid_flush, idex_en,
// idex_flush, exmem_en, exmem_flush, memwb_flush, mem_err, state_o}.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] E_IDLE   = 8'b1101_0100;
  localparam logic [7:0] E_STALL  = 8'b0001_1100;
  localparam logic [7:0] E_FREEZE = 8'b0000_0001;
  localparam logic [7:0] E_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] E_RESET  = 8'b0010_1011;
  localparam logic [7:0] E_ABORT  = 8'b1101_0111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_memread, mem_req, mem_ack, br_taken;

  logic a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush;
  logic a_exmem_en, a_exmem_flush, a_memwb_flush, a_mem_err;
  logic [1:0] a_state;
  logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush;
  logic b_exmem_en, b_exmem_flush, b_memwb_flush, b_mem_err;
  logic [1:0] b_state;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] a_lu_cnt, a_mw_cnt, a_fl_cnt, b_lu_cnt, b_mw_cnt, b_fl_cnt;
`endif

  logic [10:0] obs_a, obs_b;
  assign obs_a = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush,
                  a_exmem_en, a_exmem_flush, a_memwb_flush, a_mem_err, a_state};
  assign obs_b = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush,
                  b_exmem_en, b_exmem_flush, b_memwb_flush, b_mem_err, b_state};

  int checks = 0;
  int passed = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_USE_STALL(1), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
    .idex_en(a_idex_en), .idex_flush(a_idex_flush), .exmem_en(a_exmem_en),
    .exmem_flush(a_exmem_flush), .memwb_flush(a_memwb_flush),
    .mem_err(a_mem_err), .state_o(a_state)
`ifdef PIPE_PERF_CNT_EN
    , .lu_stall_cnt(a_lu_cnt), .mem_wait_cnt(a_mw_cnt), .flush_cnt(a_fl_cnt)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_USE_STALL(2), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
    .idex_en(b_idex_en), .idex_flush(b_idex_flush), .exmem_en(b_exmem_en),
    .exmem_flush(b_exmem_flush), .memwb_flush(b_memwb_flush),
    .mem_err(b_mem_err), .state_o(b_state)
`ifdef PIPE_PERF_CNT_EN
    , .lu_stall_cnt(b_lu_cnt), .mem_wait_cnt(b_mw_cnt), .flush_cnt(b_fl_cnt)
`endif
  );

  function automatic logic [10:0] ex(input logic [7:0] ctl, input logic err,
                                     input logic [1:0] st);
    return {ctl, err, st};
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  // Queue this cycle's expectations, sample mid-cycle, then advance to the next negedge
  task automatic cyc(input string tag, input logic [10:0] ea, input logic [10:0] eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    #2;
    check({tag, "/A"}, obs_a, q_a.pop_front());
    check({tag, "/B"}, obs_b, q_b.pop_front());
    @(negedge clk);
  endtask

  task automatic quiet();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; mem_req = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
  endtask

  // Load into r8 in ID/EX, ID instruction reads r8 via rs
  task automatic hazard();
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    @(negedge clk);
    cyc("reset", ex(E_RESET, 0, 0), ex(E_RESET, 0, 0));
    rst = 1'b0;
    cyc("idle", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Load-use: A one bubble, B two bubbles with state 0,1,0
    hazard();
    cyc("lu1", ex(E_STALL, 0, 0), ex(E_STALL, 0, 0));
    ex_memread = 1'b0;
    cyc("lu2", ex(E_IDLE, 0, 0), ex(E_STALL, 0, 1));
    quiet();
    cyc("lu3", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Hazard on rt only, and a load into r0 which is never a hazard
    ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
    cyc("lu_rt", ex(E_STALL, 0, 0), ex(E_STALL, 0, 0));
    ex_rd = 5'd0; id_rt = 5'd0;
    cyc("lu_r0", ex(E_IDLE, 0, 0), ex(E_STALL, 0, 1));
    quiet();

    // Memory wait for 3 cycles, released on ack
    mem_req = 1'b1;
    cyc("mw1", ex(E_FREEZE, 0, 0), ex(E_FREEZE, 0, 0));
    cyc("mw2", ex(E_FREEZE, 0, 2), ex(E_FREEZE, 0, 2));
    cyc("mw3", ex(E_FREEZE, 0, 2), ex(E_FREEZE, 0, 2));
    mem_ack = 1'b1;
    cyc("mw_ack", ex(E_IDLE, 0, 2), ex(E_IDLE, 0, 2));
    quiet();
    cyc("mw_done", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Store with ack already high: no stall
    mem_req = 1'b1; mem_ack = 1'b1;
    cyc("store_ack", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));
    quiet();

    // Branch beats load-use
    hazard(); br_taken = 1'b1;
    cyc("br_lu", ex(E_FLUSH, 0, 0), ex(E_FLUSH, 0, 0));
    quiet();
    cyc("br_after", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Memory wait beats branch; redirect on the ack cycle
    hazard(); br_taken = 1'b1; mem_req = 1'b1;
    cyc("mw_br1", ex(E_FREEZE, 0, 0), ex(E_FREEZE, 0, 0));
    cyc("mw_br2", ex(E_FREEZE, 0, 2), ex(E_FREEZE, 0, 2));
    mem_ack = 1'b1;
    cyc("mw_br_ack", ex(E_FLUSH, 0, 2), ex(E_FLUSH, 0, 2));
    quiet();
    cyc("mw_br_done", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Load-use applied on the ack cycle
    hazard(); mem_req = 1'b1;
    cyc("mw_lu1", ex(E_FREEZE, 0, 0), ex(E_FREEZE, 0, 0));
    mem_ack = 1'b1;
    cyc("mw_lu_ack", ex(E_STALL, 0, 2), ex(E_STALL, 0, 2));
    quiet();
    cyc("mw_lu_after", ex(E_IDLE, 0, 0), ex(E_STALL, 0, 1));
    cyc("mw_lu_done", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Memory wait interrupts B's LU_STALL; B resumes it after ack
    hazard();
    cyc("lu_int1", ex(E_STALL, 0, 0), ex(E_STALL, 0, 0));
    quiet(); mem_req = 1'b1;
    cyc("lu_int2", ex(E_FREEZE, 0, 0), ex(E_FREEZE, 0, 1));
    mem_ack = 1'b1;
    cyc("lu_int_ack", ex(E_IDLE, 0, 2), ex(E_IDLE, 0, 2));
    quiet();
    cyc("lu_int_res", ex(E_IDLE, 0, 0), ex(E_STALL, 0, 1));
    cyc("lu_int_done", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    // Timeout: 4 frozen cycles, then abort; mem_err sticky
    mem_req = 1'b1;
    cyc("to1", ex(E_FREEZE, 0, 0), ex(E_FREEZE, 0, 0));
    cyc("to2", ex(E_FREEZE, 0, 2), ex(E_FREEZE, 0, 2));
    cyc("to3", ex(E_FREEZE, 0, 2), ex(E_FREEZE, 0, 2));
    cyc("to4", ex(E_FREEZE, 0, 2), ex(E_FREEZE, 0, 2));
    cyc("to_abort", ex(E_ABORT, 0, 2), ex(E_ABORT, 0, 2));
    quiet();
    cyc("to_err", ex(E_IDLE, 1, 0), ex(E_IDLE, 1, 0));
    cyc("to_sticky", ex(E_IDLE, 1, 0), ex(E_IDLE, 1, 0));

    // Reset pulsed during MEM_WAIT
    mem_req = 1'b1;
    cyc("rw1", ex(E_FREEZE, 1, 0), ex(E_FREEZE, 1, 0));
    cyc("rw2", ex(E_FREEZE, 1, 2), ex(E_FREEZE, 1, 2));
    rst = 1'b1;
    cyc("rw_rst", ex(E_RESET, 0, 0), ex(E_RESET, 0, 0));
    cyc("rw_hold", ex(E_RESET, 0, 0), ex(E_RESET, 0, 0));
    rst = 1'b0;
    quiet();
    cyc("rw_release", ex(E_IDLE, 0, 0), ex(E_IDLE, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
